// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - shared types and instruction field positions for the program sequencer.
// PROG_SEQ_STACK_EN selects the default for the hardware return stack.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    OP_JMP  = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    PG_CUR     = 2'b00,
    PG_ZERO    = 2'b01,
    PG_PCH     = 2'b10,
    PG_CUR_ALT = 2'b11
  } pagesel_e;

  typedef enum logic [1:0] {
    CC_ALWAYS = 2'b00,
    CC_Z      = 2'b01,
    CC_C      = 2'b10,
    CC_N      = 2'b11
  } cond_e;

  localparam logic [2:0] BR_CLASS = 3'b111;
  localparam int PSW_Z = 0;
  localparam int PSW_C = 1;
  localparam int PSW_N = 7;

`ifdef PROG_SEQ_STACK_EN
  localparam bit STACK_EN_DEFAULT = 1'b1;
`else
  localparam bit STACK_EN_DEFAULT = 1'b0;
`endif

  // Field LSB positions, counted down from the instruction MSB.
  function automatic int cls_lsb(input int instr_w);
    return instr_w - 3;
  endfunction

  function automatic int op_lsb(input int instr_w);
    return instr_w - 5;
  endfunction

  function automatic int page_lsb(input int instr_w);
    return instr_w - 7;
  endfunction

  function automatic int cond_lsb(input int instr_w);
    return instr_w - 9;
  endfunction

endpackage

// File: rtl/prog_seq_dec.sv
// rtl/prog_seq_dec.sv - combinational branch-class decoder and condition evaluation.
module prog_seq_dec
  import prog_seq_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int PAGE_OFS_W = 7
) (
  input  logic [INSTR_W-1:0]    instr,
  input  logic [7:0]            psw,
  output logic                  is_br,
  output op_e                   op,
  output pagesel_e              pagesel,
  output logic                  taken,
  output logic [PAGE_OFS_W-1:0] offset
);

  localparam int CLS_LSB  = cls_lsb(INSTR_W);
  localparam int OP_LSB   = op_lsb(INSTR_W);
  localparam int PAGE_LSB = page_lsb(INSTR_W);
  localparam int COND_LSB = cond_lsb(INSTR_W);

  cond_e cond;
  logic  cond_ok;

  always_comb begin
    is_br   = (instr[CLS_LSB +: 3] == BR_CLASS);
    op      = op_e'(instr[OP_LSB +: 2]);
    pagesel = pagesel_e'(instr[PAGE_LSB +: 2]);
    cond    = cond_e'(instr[COND_LSB +: 2]);
    offset  = instr[PAGE_OFS_W-1:0];
    cond_ok = 1'b1;
    case (cond)
      CC_Z:    cond_ok = psw[PSW_Z];
      CC_C:    cond_ok = psw[PSW_C];
      CC_N:    cond_ok = psw[PSW_N];
      default: cond_ok = 1'b1;
    endcase
    // NOP is a branch-class word that never redirects the PC.
    taken = is_br && cond_ok && (op != OP_NOP);
  end

  logic unused_psw;
  assign unused_psw = ^psw[6:2];

endmodule

// File: rtl/prog_seq.sv
// rtl/prog_seq.sv - program sequencer: PC, paged branches, CALL/RET return stack, HOLD stall.
// Return stack present when PROG_SEQ_STACK_EN is defined (STACK_EN parameter default).
module prog_seq
  import prog_seq_pkg::*;
#(
  parameter int PC_W        = 15,
  parameter int PAGE_OFS_W  = 7,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4,
  parameter bit STACK_EN    = STACK_EN_DEFAULT,
  localparam int PAGE_W     = PC_W - PAGE_OFS_W,
  localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               HOLD,
  input  logic [7:0]         PSW,
  input  logic [PAGE_W-1:0]  PCH,
  output logic [PC_W-1:0]    IMEM_ADDR,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  output logic [INSTR_W-1:0] INSTR,
  output logic [SP_W-1:0]    SP,
  output logic               STACK_OVF,
  output logic               STACK_UNF
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic                  is_br;
  op_e                   op;
  pagesel_e              pagesel;
  logic                  taken;
  logic [PAGE_OFS_W-1:0] offset;

  logic [PC_W-1:0]   pc, pc_inc, pc_next, target, top_addr;
  logic [PAGE_W-1:0] page;
  logic              do_jmp, do_call, do_ret, ret_ok;

  prog_seq_dec #(
    .INSTR_W   (INSTR_W),
    .PAGE_OFS_W(PAGE_OFS_W)
  ) u_dec (
    .instr  (IMEM_DATA),
    .psw    (PSW),
    .is_br  (is_br),
    .op     (op),
    .pagesel(pagesel),
    .taken  (taken),
    .offset (offset)
  );

  assign IMEM_ADDR = pc;
  assign INSTR     = IMEM_DATA;

  always_comb begin
    pc_inc  = pc + PC_ONE;
    do_jmp  = is_br && taken && (op == OP_JMP);
    do_call = is_br && taken && (op == OP_CALL);
    do_ret  = is_br && taken && (op == OP_RET);
    case (pagesel)
      PG_ZERO: page = '0;
      PG_PCH:  page = PCH;
      default: page = pc[PC_W-1:PAGE_OFS_W];
    endcase
    target = {page, offset};
    // Without a stack ret_ok stays 0, so CALL degrades to JMP and RET to PC+1.
    pc_next = pc_inc;
    if (do_jmp || do_call) begin
      pc_next = target;
    end else if (do_ret && ret_ok) begin
      pc_next = top_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      pc <= '0;
    end else if (!HOLD) begin
      pc <= pc_next;
    end
  end

  if (STACK_EN) begin : g_stack
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);

    logic [PC_W-1:0]  mem [STACK_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [SP_W-1:0]  sp_q;
    logic             ovf_q, unf_q;

    assign ret_ok    = (sp_q != '0);
    assign top_addr  = mem[wr_ptr - PTR_ONE];
    assign SP        = sp_q;
    assign STACK_OVF = ovf_q;
    assign STACK_UNF = unf_q;

    // wr_ptr always points at the oldest slot once full, so a push overwrites it.
    always_ff @(posedge CLK) begin
      if (nRESET && !HOLD && do_call) begin
        mem[wr_ptr] <= pc_inc;
      end
    end

    always_ff @(posedge CLK) begin
      if (!nRESET) begin
        wr_ptr <= '0;
        sp_q   <= '0;
        ovf_q  <= 1'b0;
        unf_q  <= 1'b0;
      end else if (!HOLD) begin
        if (do_call) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (sp_q == SP_FULL) begin
            ovf_q <= 1'b1;
          end else begin
            sp_q <= sp_q + SP_ONE;
          end
        end else if (do_ret) begin
          if (ret_ok) begin
            wr_ptr <= wr_ptr - PTR_ONE;
            sp_q   <= sp_q - SP_ONE;
          end else begin
            unf_q <= 1'b1;
          end
        end
      end
    end
  end else begin : g_no_stack
    assign ret_ok    = 1'b0;
    assign top_addr  = '0;
    assign SP        = '0;
    assign STACK_OVF = 1'b0;
    assign STACK_UNF = 1'b0;
  end

endmodule

// File: tb/tb_prog_seq.sv
// tb/tb_prog_seq.sv - directed bench: stack-enabled instance plus default-build instance.
module tb_prog_seq;

`ifdef PROG_SEQ_STACK_EN
  localparam bit DEF_STK = 1'b1;
`else
  localparam bit DEF_STK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRESET, HOLD;
  logic [7:0]  PSW, PCH;
  logic [15:0] imem_s, imem_d, instr_s, instr_d;
  logic [14:0] addr_s, addr_d;
  logic [2:0]  sp_s, sp_d;
  logic        ovf_s, unf_s, ovf_d, unf_d;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 CLK = ~CLK;

  prog_seq #(.STACK_EN(1'b1)) dut_s (
    .CLK(CLK), .nRESET(nRESET), .HOLD(HOLD), .PSW(PSW), .PCH(PCH),
    .IMEM_ADDR(addr_s), .IMEM_DATA(imem_s), .INSTR(instr_s),
    .SP(sp_s), .STACK_OVF(ovf_s), .STACK_UNF(unf_s)
  );

  prog_seq dut_d (
    .CLK(CLK), .nRESET(nRESET), .HOLD(HOLD), .PSW(PSW), .PCH(PCH),
    .IMEM_ADDR(addr_d), .IMEM_DATA(imem_d), .INSTR(instr_d),
    .SP(sp_d), .STACK_OVF(ovf_d), .STACK_UNF(unf_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input int pc, input int sp, input bit ovf, input bit unf);
    chk({tag, "_pc"}, 32'(addr_s), pc);
    chk({tag, "_sp"}, 32'(sp_s), sp);
    chk({tag, "_ovf"}, 32'(ovf_s), 32'(ovf));
    chk({tag, "_unf"}, 32'(unf_s), 32'(unf));
  endtask

  task automatic step(input logic [15:0] is, input logic [15:0] id);
    imem_s = is;
    imem_d = id;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRESET = 1'b0; HOLD = 1'b0; PSW = 8'h00; PCH = 8'h00;
    imem_s = 16'h0000; imem_d = 16'h0000;
    step(16'h0000, 16'h0000);
    step(16'h0000, 16'h0000);
    chk_s("reset", 0, 0, 1'b0, 1'b0);
    chk("reset_d_pc", 32'(addr_d), 0);
    chk("reset_d_sp", 32'(sp_d), 0);

    nRESET = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(16'h0000, 16'h0000);
      chk("run_pc_s", 32'(addr_s), i);
      chk("run_pc_d", 32'(addr_d), i);
    end
    chk_s("run", 4, 0, 1'b0, 1'b0);
    step(16'h0000, 16'h0000);
    chk("run_pc5", 32'(addr_s), 5);

    imem_s = 16'hE003;
    #1 chk("instr_pass", 32'(instr_s), 32'h0000E003);
    step(16'hE003, 16'h0000);  chk_s("jmp_cur", 'h003, 0, 1'b0, 1'b0);
    PCH = 8'h12;
    step(16'hE403, 16'h0000);  chk("jmp_pch", 32'(addr_s), 'h903);
    step(16'hE083, 16'h0000);  chk("cz_false", 32'(addr_s), 'h904);
    step(16'hE205, 16'h0000);  chk("jmp_pg0", 32'(addr_s), 'h005);
    PSW = 8'h01;
    step(16'hE083, 16'h0000);  chk("cz_true", 32'(addr_s), 'h003);
    step(16'hE183, 16'h0000);  chk("cn_false", 32'(addr_s), 'h004);
    PSW = 8'h80;
    step(16'hE183, 16'h0000);  chk("cn_true", 32'(addr_s), 'h003);
    PSW = 8'h02;
    step(16'hE103, 16'h0000);  chk("cc_true", 32'(addr_s), 'h003);
    PSW = 8'h00;
    step(16'hE47F, 16'h0000);  chk("jmp_pch2", 32'(addr_s), 'h97F);
    step(16'hE601, 16'h0000);  chk("jmp_cur11", 32'(addr_s), 'h901);
    step(16'hF803, 16'h0000);  chk("br_nop", 32'(addr_s), 'h902);

    step(16'hE210, 16'h0000);  chk("jmp_010", 32'(addr_s), 'h010);
    step(16'hE820, 16'h0000);  chk_s("call", 'h020, 1, 1'b0, 1'b0);
    step(16'hF000, 16'h0000);  chk_s("ret", 'h011, 0, 1'b0, 1'b0);
    step(16'hE8A0, 16'h0000);  chk_s("call_cf", 'h012, 0, 1'b0, 1'b0);

    step(16'hE830, 16'h0000);  chk_s("c1", 'h030, 1, 1'b0, 1'b0);
    step(16'hE840, 16'h0000);  chk_s("c2", 'h040, 2, 1'b0, 1'b0);
    step(16'hE850, 16'h0000);  chk_s("c3", 'h050, 3, 1'b0, 1'b0);
    step(16'hE860, 16'h0000);  chk_s("c4", 'h060, 4, 1'b0, 1'b0);
    step(16'hE870, 16'h0000);  chk_s("c5_ovf", 'h070, 4, 1'b1, 1'b0);
    step(16'hF000, 16'h0000);  chk_s("r1", 'h061, 3, 1'b1, 1'b0);
    step(16'hF000, 16'h0000);  chk_s("r2", 'h051, 2, 1'b1, 1'b0);
    step(16'hF000, 16'h0000);  chk_s("r3", 'h041, 1, 1'b1, 1'b0);
    step(16'hF000, 16'h0000);  chk_s("r4", 'h031, 0, 1'b1, 1'b0);
    step(16'hF000, 16'h0000);  chk_s("r5_unf", 'h032, 0, 1'b1, 1'b1);

    HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(16'hE820, 16'h0000);
      chk_s("hold", 'h032, 0, 1'b1, 1'b1);
    end
    HOLD = 1'b0;
    step(16'hE820, 16'h0000);  chk_s("hold_rel", 'h020, 1, 1'b1, 1'b1);
    step(16'hF000, 16'h0000);  chk_s("hold_ret", 'h033, 0, 1'b1, 1'b1);

    PCH = 8'hFF;
    step(16'hE47F, 16'h0000);  chk("pc_max", 32'(addr_s), 'h7FFF);
    step(16'h0000, 16'h0000);  chk("pc_wrap", 32'(addr_s), 'h0000);

    step(16'hE820, 16'h0000);  chk_s("pre_rst", 'h020, 1, 1'b1, 1'b1);
    nRESET = 1'b0; HOLD = 1'b1;
    step(16'hE830, 16'h0000);  chk_s("rst_hold", 0, 0, 1'b0, 1'b0);
    nRESET = 1'b1; HOLD = 1'b0;
    step(16'hF000, 16'h0000);  chk_s("post_rst_ret", 'h001, 0, 1'b0, 1'b1);

    step(16'h0000, 16'hE210);  chk("d_jmp", 32'(addr_d), 'h010);
    step(16'h0000, 16'hE820);
    chk("d_call_pc", 32'(addr_d), 'h020);
    chk("d_call_sp", 32'(sp_d), DEF_STK ? 1 : 0);
    step(16'h0000, 16'hF000);
    chk("d_ret_pc", 32'(addr_d), DEF_STK ? 'h011 : 'h021);
    chk("d_ret_sp", 32'(sp_d), 0);
    chk("d_ret_unf", 32'(unf_d), 0);
    imem_d = 16'hE870;
    #1 chk("d_instr", 32'(instr_d), 32'h0000E870);
    step(16'h0000, 16'hE870);
    chk("d_call2_pc", 32'(addr_d), 'h070);
    chk("d_call2_sp", 32'(sp_d), DEF_STK ? 1 : 0);
    chk("d_call2_ovf", 32'(ovf_d), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
